// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, runs the req/ack read into instruction memory,
// presents the captured word to Control and resolves the next PC on commit.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] Instruction,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  input  logic        commit,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_target,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t state, nextState;

  logic fetchDone;
  logic retire;
  logic jrMisaligned;

  function automatic logic [31:0] nextPc(
    input logic [1:0]  src,
    input logic        br,
    input logic        zr,
    input logic [31:0] pcPlus4,
    input logic [31:0] inst,
    input logic [31:0] jrTarget
  );
    logic signed [31:0] branchOff;
    branchOff = {{14{inst[15]}}, inst[15:0], 2'b00};
    case (src)
      2'b10:   nextPc = {jrTarget[31:2], 2'b00};
      2'b01:   nextPc = {pcPlus4[31:28], inst[25:0], 2'b00};
      2'b00:   nextPc = (br && zr) ? pcPlus4 + $unsigned(branchOff) : pcPlus4;
      default: nextPc = pcPlus4;
    endcase
  endfunction

  assign fetchDone    = (state == FETCH) && imem_ack;
  assign retire       = (state == HOLD) && commit;
  assign jrMisaligned = (PCSrc == 2'b10) && (jr_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = FETCH;
      FETCH:   if (imem_ack) nextState = HOLD;
      HOLD:    if (commit) nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state == FETCH);
    inst_valid = (state == HOLD);
  end

  // Reset also clears Instruction so an ack landing on the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC          <= RESET_PC;
      Instruction <= 32'h0000_0000;
      align_err   <= 1'b0;
    end else begin
      if (fetchDone) begin
        Instruction <= imem_rdata;
      end
      if (retire) begin
        PC <= nextPc(PCSrc, Branch, Zero, PC_plus_4, Instruction, jr_target);
        if (jrMisaligned) begin
          align_err <= 1'b1;
        end
      end
    end
  end

  assign imem_addr = {PC[31:2], 2'b00};
  assign PC_plus_4 = PC + 32'd4;
  assign OpCode    = Instruction[31:26];
  assign Funct     = Instruction[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a driver plays memory and datapath while
// a monitor compares every fetch address and presented instruction.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] Instruction;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic        commit;
  logic [1:0]  PCSrc;
  logic        Branch;
  logic        Zero;
  logic [31:0] jr_target;
  logic        align_err;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .Instruction(Instruction),
    .OpCode(OpCode), .Funct(Funct), .PC(PC), .PC_plus_4(PC_plus_4),
    .commit(commit), .PCSrc(PCSrc), .Branch(Branch), .Zero(Zero),
    .jr_target(jr_target), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        al;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] addrQ[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] mPc;
  logic        mAlign;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expected address on each new request and an expected
  // instruction record each time inst_valid rises.
  initial begin
    logic  prevReq, prevValid;
    logic [31:0] curAddr;
    exp_t  cur;
    prevReq = 1'b0;
    prevValid = 1'b0;
    curAddr = '0;
    cur = '{pc: '0, inst: '0, al: 1'b0};
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1 && !prevReq) begin
        total++;
        if (addrQ.size() == 0) begin
          bad++;
          $display("FAIL unexpected_req: got addr %h required no request", imem_addr);
        end else begin
          curAddr = addrQ.pop_front();
        end
      end
      if (imem_req === 1'b1) check("imem_addr", imem_addr, curAddr);
      if (inst_valid === 1'b1 && !prevValid) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: got inst %h required none", Instruction);
        end else begin
          cur = expQ.pop_front();
          check("PC", PC, cur.pc);
          check("Instruction", Instruction, cur.inst);
          check("OpCode", {26'b0, OpCode}, {26'b0, cur.inst[31:26]});
          check("Funct", {26'b0, Funct}, {26'b0, cur.inst[5:0]});
          check("PC_plus_4", PC_plus_4, cur.pc + 32'd4);
          check("align_err", {31'b0, align_err}, {31'b0, cur.al});
        end
      end else if (inst_valid === 1'b1) begin
        check("hold_Instruction", Instruction, cur.inst);
        check("hold_PC", PC, cur.pc);
      end
      prevReq   = (imem_req === 1'b1);
      prevValid = (inst_valid === 1'b1);
    end
  end

  task automatic waitReq();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      $display("FAIL req_timeout: got imem_req=%b required 1", imem_req);
      $fatal(1, "fetch request never arrived");
    end
  endtask

  // One full instruction: memory answers after `waits` cycles, then the
  // datapath commits with the given control; the model predicts the next PC.
  task automatic doInstr(input logic [31:0] instr, input int waits, input logic [1:0] src,
                         input logic br, input logic zr, input logic [31:0] jr, input bit stray);
    logic [31:0] pc4, nxt;
    int holdN;
    waitReq();
    for (int i = 0; i < waits; i++) begin
      commit = stray;
      PCSrc = 2'b01;
      @(negedge clk);
    end
    commit = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = instr;
    expQ.push_back('{pc: mPc, inst: instr, al: mAlign});
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    holdN = stray ? 2 : $urandom_range(0, 2);
    for (int i = 0; i < holdN; i++) begin
      imem_ack = stray;
      imem_rdata = ~instr;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    pc4 = mPc + 32'd4;
    if (src == 2'b10) begin
      nxt = jr & 32'hFFFF_FFFC;
      if (jr % 4 != 0) mAlign = 1'b1;
    end else if (src == 2'b01) begin
      nxt = (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    end else if (src == 2'b00 && br && zr) begin
      nxt = pc4 + 32'(int'($signed(instr[15:0])) * 4);
    end else begin
      nxt = pc4;
    end
    mPc = nxt;
    addrQ.push_back(nxt);
    commit = 1'b1;
    PCSrc = src;
    Branch = br;
    Zero = zr;
    jr_target = jr;
    @(negedge clk);
    commit = 1'b0;
    Branch = $urandom;
    Zero = $urandom;
    jr_target = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rInst, rJr;
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    commit = 1'b0;
    PCSrc = 2'b00;
    Branch = 1'b0;
    Zero = 1'b0;
    jr_target = '0;
    mPc = 32'h0000_0000;
    mAlign = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_PC", PC, 32'h0000_0000);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_Instruction", Instruction, 32'h0000_0000);
    check("rst_align", {31'b0, align_err}, 32'd0);
    addrQ.push_back(32'h0000_0000);
    reset = 1'b0;
    @(negedge clk);
    check("req_after_idle", {31'b0, imem_req}, 32'd1);

    doInstr(32'h2008_0005, 3, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    doInstr(32'h0000_0020, 0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
    doInstr(32'h0000_0020, 1, 2'b11, 1'b1, 1'b1, 32'h0, 1'b1);
    doInstr(32'h0000_0020, 0, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
    doInstr(32'h1022_FFFE, 2, 2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
    doInstr(32'h0000_0020, 0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    doInstr(32'h1022_FFFE, 0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
    doInstr(32'h03E0_0008, 1, 2'b10, 1'b0, 1'b0, 32'h1000_0000, 1'b1);
    doInstr(32'h0800_0040, 0, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0);
    doInstr(32'h0060_0008, 2, 2'b10, 1'b0, 1'b0, 32'h0000_0203, 1'b1);
    doInstr(32'h0060_0008, 0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    doInstr(32'h0000_0020, 1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      rInst = $urandom;
      rJr = $urandom;
      if ($urandom_range(0, 3) != 0) rJr[1:0] = 2'b00;
      doInstr(rInst, $urandom_range(0, 3), 2'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), rJr, ($urandom_range(0, 3) == 0));
    end

    waitReq();
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("rstack_valid", {31'b0, inst_valid}, 32'd0);
    check("rstack_req", {31'b0, imem_req}, 32'd0);
    check("rstack_PC", PC, 32'h0000_0000);
    check("rstack_Instruction", Instruction, 32'h0000_0000);
    check("rstack_align", {31'b0, align_err}, 32'd0);
    mPc = 32'h0000_0000;
    mAlign = 1'b0;
    addrQ.push_back(32'h0000_0000);
    reset = 1'b0;
    doInstr(32'h8C01_0004, 1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    waitReq();
    repeat (3) @(negedge clk);

    check("expQ_drained", 32'(expQ.size()), 32'd0);
    check("addrQ_drained", 32'(addrQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
